fwd_hazard_ctrl: RTL
====================

# fwd_hazard_ctrl

Forwarding and hazard controller for the 5-stage pipeline. It is the producer of the select signals consumed by the decode-stage source mux, and also of the execute-stage forwarding selects. It tracks the destination register of every in-flight instruction in E, M and W. From that state it drives forwarding selects, load-use stall, branch flush and bubble insertion, and, optionally, a multi-cycle mul/div hold.

## Interface
Parameters:
- MULDIV_LAT, 4: total E-stage cycles of a mul/div op; used only when MULDIV_STALL_EN is defined; legal range 2..15.

Ports (one clock; reset is asynchronous, active-high):
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous active-high reset
- D_valid  in  1  D stage holds a real instruction
- D_rs1_index, D_rs2_index  in  5 each  D-stage source register numbers
- D_rs1_used, D_rs2_used  in  1 each  source actually read
- D_rd_index  in  5  D-stage destination register
- D_wb_en  in  1  D instruction writes rd
- D_is_load  in  1  D instruction is a load
- D_is_muldiv  in  1  D instruction is mul/div (ignored without macro)
- E_branch_taken  in  1  branch or jump resolved taken in E
- D_rs1_sel, D_rs2_sel  out  1 each  1 = take the WB write-back value instead of regfile output
- E_rs1_sel, E_rs2_sel  out  2 each  0 = ID/EX operand, 1 = MEM ALU result, 2 = WB value
- stall  out  1  hold PC and F/D register
- flush  out  1  squash F/D and D/E contents
- E_hold  out  1  hold the D/E register (always 0 without macro)

## Operation
- Three tracking slots E, M, W, each holding {valid, rd, wb_en, is_load}. Slot E additionally holds rs1/rs2 index and used bits.
- A slot is a producer of register r iff valid & wb_en & rd==r & r!=0.
- D-stage selects (D_rs1_sel, D_rs2_sel): 1 iff W is a producer of the D source and that source is used.
- E-stage selects (E_rs1_sel, E_rs2_sel):
  - 1 if M is a non-load producer of the E source.
  - Otherwise 2 if W is a producer.
  - Otherwise 0.
  - M has priority over W, giving youngest-wins.
- Load-use stall: stall=1 when E is a load producer of a used, valid D source.
- Per-cycle advance, normal: W<=M, M<=E, E<=D fields (valid=D_valid).
- Per-cycle advance, on stall: W<=M, M<=E, E<=bubble (valid=0); D is held upstream.
- Per-cycle advance, on flush: E<=bubble. flush = E_branch_taken. Flush overrides stall: stall forced to 0 in a flush cycle.
- All selects and stall/flush are combinational from slot state and D inputs. There are no other registered outputs.

## Timing
- Reset: all slots valid=0 and the mul/div counter = 0. Therefore every output is 0 during and immediately after reset.
- Reset asserted mid-operation discards all tracked state on the same edge.
- Load-use penalty: exactly 1 stall cycle. The consumer then reaches E with the load in W, giving E_sel=2.
- Back-to-back writers of the same rd: the younger one (M) wins over W.
- rd=x0 never forwards and never stalls.
- Simultaneous events:
  - Load-use and branch_taken in the same cycle: flush=1, stall=0.
  - Mul/div hold takes precedence over load-use stall.

## Configuration
- MULDIV_STALL_EN defined:
  - When a valid D_is_muldiv instruction enters E, a 4-bit counter loads MULDIV_LAT-1.
  - While the counter is nonzero: E_hold=1 and stall=1; E is held; M<=bubble; W<=M; the counter decrements.
  - When the counter reaches 0, the pipeline advances normally.
  - flush cannot assert during a hold, because the mul/div occupies E.
- MULDIV_STALL_EN undefined: no counter; D_is_muldiv is ignored; E_hold is tied to 0.

## Structure
- Shared package pipe_pkg holds:
  - the fwd_sel_t enum (FWD_RF=0, FWD_MEM=1, FWD_WB=2);
  - the hz_slot_t struct {valid, rd, wb_en, is_load};
  - the REG_IDX_W=5 constant.
- One sub-module, fwd_match: given a slot and a source index, it returns the producer hit. It is instantiated for each slot/source pair.

## Test plan
- Reset asserted while slots are full: all outputs 0 on the next cycle; no forwarding until new instructions enter.
- ALU add x5 followed by a use of x5 in the next instruction: consumer in E sees E_rs1_sel=1. One instruction later: E_rs1_sel=2. Two later: D_rs1_sel=1.
- lw x7 followed by add x8,x7,x7: stall=1 for exactly one cycle with an E bubble; then E_rs1_sel=E_rs2_sel=2.
- Two writes to x9 in sequence, then a read of x9: E_rs1_sel=1 (youngest wins), not 2.
- Writes to x0, then a read of x0: all selects 0, stall 0.
- lw x3 in E with a D consumer of x3, and E_branch_taken=1 in the same cycle: flush=1, stall=0, E becomes a bubble. With MULDIV_STALL_EN and MULDIV_LAT=4: mul gives stall=E_hold=1 for 3 cycles.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types: forwarding select encoding, hazard tracking slot
// layout and register index width.
package pipe_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic                 wb_en;
        logic                 is_load;
    } hz_slot_t;

    localparam hz_slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/fwd_match.sv
// Producer match: a tracked slot produces register src when it is a valid
// writer of that register and the register is not x0.
module fwd_match
    import pipe_pkg::*;
(
    input  hz_slot_t             slot,
    input  logic [REG_IDX_W-1:0] src,
    output logic                 hit
);

    assign hit = slot.valid && slot.wb_en && (slot.rd == src) && (src != '0);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / hazard controller for the 5-stage pipeline: tracks E/M/W
// destinations and drives forwarding selects, load-use stall and flush.
// Optional mul/div hold is built when MULDIV_STALL_EN is defined.
module fwd_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MULDIV_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 D_valid,
    input  logic [REG_IDX_W-1:0] D_rs1_index,
    input  logic [REG_IDX_W-1:0] D_rs2_index,
    input  logic                 D_rs1_used,
    input  logic                 D_rs2_used,
    input  logic [REG_IDX_W-1:0] D_rd_index,
    input  logic                 D_wb_en,
    input  logic                 D_is_load,
    input  logic                 D_is_muldiv,
    input  logic                 E_branch_taken,
    output logic                 D_rs1_sel,
    output logic                 D_rs2_sel,
    output logic [1:0]           E_rs1_sel,
    output logic [1:0]           E_rs2_sel,
    output logic                 stall,
    output logic                 flush,
    output logic                 E_hold
);

    hz_slot_t             e_slot_reg;
    hz_slot_t             m_slot_reg;
    hz_slot_t             w_slot_reg;
    logic [REG_IDX_W-1:0] e_rs1_reg;
    logic [REG_IDX_W-1:0] e_rs2_reg;
    logic [1:0]           e_used_reg;

    logic [REG_IDX_W-1:0] d_src [2];
    logic [REG_IDX_W-1:0] e_src [2];
    logic [1:0]           d_used;
    logic [1:0]           d_hit_e;
    logic [1:0]           d_hit_w;
    logic [1:0]           e_hit_m;
    logic [1:0]           e_hit_w;
    logic [1:0]           load_use;
    fwd_sel_t             e_sel [2];
    logic                 hold;

    assign d_src[0] = D_rs1_index;
    assign d_src[1] = D_rs2_index;
    assign e_src[0] = e_rs1_reg;
    assign e_src[1] = e_rs2_reg;
    assign d_used   = {D_rs2_used, D_rs1_used};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            fwd_match u_d_e (.slot(e_slot_reg), .src(d_src[gi]), .hit(d_hit_e[gi]));
            fwd_match u_d_w (.slot(w_slot_reg), .src(d_src[gi]), .hit(d_hit_w[gi]));
            fwd_match u_e_m (.slot(m_slot_reg), .src(e_src[gi]), .hit(e_hit_m[gi]));
            fwd_match u_e_w (.slot(w_slot_reg), .src(e_src[gi]), .hit(e_hit_w[gi]));

            assign load_use[gi] = D_valid && d_used[gi] && d_hit_e[gi] && e_slot_reg.is_load;

            // A load in M has no data yet; it can only be forwarded once in W.
            assign e_sel[gi] = (e_used_reg[gi] && e_hit_m[gi] && !m_slot_reg.is_load) ? FWD_MEM :
                               (e_used_reg[gi] && e_hit_w[gi])                        ? FWD_WB  :
                                                                                         FWD_RF;
        end
    endgenerate

    assign D_rs1_sel = d_hit_w[0] && D_rs1_used;
    assign D_rs2_sel = d_hit_w[1] && D_rs2_used;
    assign E_rs1_sel = e_sel[0];
    assign E_rs2_sel = e_sel[1];

    assign flush  = E_branch_taken && !hold;
    assign stall  = hold || ((|load_use) && !flush);
    assign E_hold = hold;

`ifdef MULDIV_STALL_EN
    logic [3:0] mdiv_cnt_reg;

    assign hold = (mdiv_cnt_reg != 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdiv_cnt_reg <= 4'd0;
        end else if (hold) begin
            mdiv_cnt_reg <= mdiv_cnt_reg - 4'd1;
        end else if (D_valid && D_is_muldiv && !stall && !flush) begin
            mdiv_cnt_reg <= 4'(MULDIV_LAT - 1);
        end
    end
`else
    logic [4:0] muldiv_cfg_unused;

    assign muldiv_cfg_unused = {D_is_muldiv, 4'(MULDIV_LAT - 1)};
    assign hold              = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_slot_reg <= SLOT_BUBBLE;
            m_slot_reg <= SLOT_BUBBLE;
            w_slot_reg <= SLOT_BUBBLE;
            e_rs1_reg  <= '0;
            e_rs2_reg  <= '0;
            e_used_reg <= '0;
        end else if (hold) begin
            // Mul/div stays in E; M drains a bubble behind it.
            w_slot_reg <= m_slot_reg;
            m_slot_reg <= SLOT_BUBBLE;
        end else begin
            w_slot_reg <= m_slot_reg;
            m_slot_reg <= e_slot_reg;
            if (stall || flush) begin
                e_slot_reg <= SLOT_BUBBLE;
                e_rs1_reg  <= '0;
                e_rs2_reg  <= '0;
                e_used_reg <= '0;
            end else begin
                e_slot_reg <= '{valid: D_valid, rd: D_rd_index, wb_en: D_wb_en, is_load: D_is_load};
                e_rs1_reg  <= D_rs1_index;
                e_rs2_reg  <= D_rs2_index;
                e_used_reg <= d_used;
            end
        end
    end

endmodule
